// File: rtl/dff_pipe_if.sv
// dff_pipe_if: valid/ready bus for the dff_pipe register chain.
// master drives the upstream data, the downstream ready and flush.
// slave is the pipe itself.
interface dff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;

  modport master (
    output flush, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count
  );

  modport slave (
    input  flush, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count
  );
endinterface

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage stallable register pipe with per-stage valid bits,
// bubble-collapsing ready chain, synchronous flush and occupancy count.
// Build option DFF_PIPE_RESET_DATA_EN: when defined, data registers are
// reset asynchronously to RESET_VAL together with the valid bits; when not
// defined, data registers carry no reset.
module dff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic      clk,
  input  logic      rst,
  dff_pipe_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic             accept;

  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  // Ready chain: a stage can load if it is empty or the stage after it loads.
  always_comb begin
    logic chain;
    chain = bus.out_ready;
    rdy   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain  = !vld_q[i] || chain;
      rdy[i] = chain;
    end
  end

  assign bus.in_ready = rdy[0] && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  // Valid bits and count: shift where ready, hold where stalled, clear on flush.
  always_comb begin
    vld_d = vld_q;
    if (bus.flush) begin
      vld_d = '0;
    end else begin
      if (rdy[0]) begin
        vld_d[0] = accept;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          vld_d[i] = vld_q[i-1];
        end
      end
    end
    cnt_d = popcount(vld_d);
  end

  // Data moves with the ready chain; contents of empty stages are don't-care.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end
    if (accept) begin
      data_d[0] = bus.in_data;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (rdy[i]) begin
        data_d[i] = data_q[i-1];
      end
    end
  end

  // Control state: valid bits and occupancy, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef DFF_PIPE_RESET_DATA_EN
  // Data registers with asynchronous reset to RESET_VAL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end
`else
  // Reset value has no data register to load in this build.
  logic [WIDTH-1:0] unused_reset_val;
  assign unused_reset_val = RESET_VAL;

  // Reset-free data registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      data_q[i] <= data_d[i];
    end
  end
`endif

  assign bus.out_valid = vld_q[DEPTH-1];
  assign bus.out_data  = data_q[DEPTH-1];
  assign bus.count     = cnt_q;
endmodule
